// File: rtl/pwm_duty_meas.sv
// PWM receiver: measures high width, period and 8-bit duty between rising edges,
// with stuck-high/low timeout. Optional glitch filter: define PWM_MEAS_GLITCH_FILT_EN.
module pwm_duty_meas #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 512,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  // state | meaning
  // ACQ   | no reference rising edge seen yet
  // MEAS  | reference edge held, each rise closes a period
  // STUCK | no rise for TIMEOUT cycles, flags report the level
  typedef enum logic [1:0] {ACQ, MEAS, STUCK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  if (FILT_LEN < 2 || CNT_W < 9 || TIMEOUT >= (2 ** CNT_W)) begin : g_param_chk
    $error("pwm_duty_meas: need FILT_LEN>=2, CNT_W>=9, TIMEOUT<2**CNT_W");
  end

  logic             sync1, sync2, pwm_s, pwm_d, rise, timeout;
  logic [CNT_W-1:0] per_c, hi_c, hi_m1, period_meas;
  logic [7:0]       duty_meas;
  state_t           state, state_nx;
  logic             valid_nx, hi_nx, lo_nx;
  logic [CNT_W-1:0] high_nx, period_nx;
  logic [7:0]       duty_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_MEAS_GLITCH_FILT_EN
  localparam int FC_W = $clog2(FILT_LEN) + 1;
  logic [FC_W-1:0] filt_cnt;
  logic            pwm_f;

  // sync1 is the look-ahead sample, so a change is taken after FILT_LEN pwm_in samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      pwm_f    <= 1'b0;
    end else if (sync2 != pwm_f && sync1 == sync2) begin
      if (filt_cnt == FC_W'(FILT_LEN - 2)) begin
        pwm_f    <= sync2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign pwm_s = pwm_f;
`else
  assign pwm_s = sync2;
`endif

  assign rise    = pwm_s & ~pwm_d;
  assign timeout = (per_c == TO_LAST) && !rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_d <= 1'b0;
      per_c <= '0;
      hi_c  <= '0;
    end else begin
      pwm_d <= pwm_s;
      if (rise) begin
        per_c <= '0;
        hi_c  <= CNT_W'(1);
      end else begin
        if (per_c != CNT_MAX) per_c <= per_c + 1'b1;
        if (pwm_s && hi_c != CNT_MAX) hi_c <= hi_c + 1'b1;
      end
    end
  end

  assign hi_m1       = hi_c - 1'b1;
  assign period_meas = (per_c == CNT_MAX) ? CNT_MAX : per_c + 1'b1;
  assign duty_meas   = (hi_c == '0) ? 8'h00 :
                       (|hi_m1[CNT_W-1:8]) ? 8'hFF : hi_m1[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACQ;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    valid_nx  = 1'b0;
    high_nx   = high_cnt;
    period_nx = period_cnt;
    duty_nx   = duty;
    hi_nx     = stuck_hi;
    lo_nx     = stuck_lo;
    case (state)
      ACQ, MEAS: begin
        if (rise) begin
          state_nx = MEAS;
          if (state == MEAS) begin
            valid_nx  = 1'b1;
            high_nx   = hi_c;
            period_nx = period_meas;
            duty_nx   = duty_meas;
          end
        end else if (timeout) begin
          state_nx = STUCK;
          valid_nx = 1'b1;
          hi_nx    = pwm_s;
          lo_nx    = ~pwm_s;
          duty_nx  = pwm_s ? 8'hFF : 8'h00;
        end
      end
      STUCK: begin
        if (rise) begin
          state_nx = MEAS;
          hi_nx    = 1'b0;
          lo_nx    = 1'b0;
        end
      end
      default: state_nx = ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      duty       <= 8'h00;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      meas_valid <= valid_nx;
      high_cnt   <= high_nx;
      period_cnt <= period_nx;
      duty       <= duty_nx;
      stuck_hi   <= hi_nx;
      stuck_lo   <= lo_nx;
    end
  end

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Bench for pwm_duty_meas: table of generator settings plus hand-written sequences
// for duty change, stuck recovery, mid-period reset and short glitches.
module tb_pwm_duty_meas;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        meas_valid;
  logic [15:0] high_cnt, period_cnt;
  logic [7:0]  duty;
  logic        stuck_hi, stuck_lo;

  pwm_duty_meas dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .meas_valid(meas_valid),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty(duty),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int high; int period; int duty; bit hi; bit lo;
  } cap_t;

  typedef struct {
    string      name;
    bit         is_gen;
    logic [7:0] set;
    int         ncyc;
    int         exp_nv;
    int         exp_high;
    int         exp_period;
    int         exp_duty;
    bit         exp_hi;
    bit         exp_lo;
  } vec_t;

  cap_t caps[$];
  int   dbl_cnt = 0;
  bit   prev_v  = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  // generator model: high while counter <= setting, 256-cycle period
  bit         gen_on  = 1'b0;
  logic [7:0] gen_set = 8'h00;
  logic [7:0] gen_g   = 8'h00;
  bit         lvl     = 1'b0;

  always @(negedge clk) begin
    if (meas_valid) begin
      caps.push_back('{int'(high_cnt), int'(period_cnt), int'(duty), stuck_hi, stuck_lo});
      if (prev_v) dbl_cnt++;
    end
    prev_v = meas_valid;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gen_on) begin
        pwm_in = (gen_g <= gen_set);
        gen_g  = gen_g + 8'd1;
      end else begin
        pwm_in = lvl;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    gen_on = 1'b0;
    lvl    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_cap(input string nm, input int idx, input int h, input int p,
                         input int d, input bit shi, input bit slo);
    if (idx < caps.size()) begin
      chk({nm, "_high"}, caps[idx].high, h);
      chk({nm, "_period"}, caps[idx].period, p);
      chk({nm, "_duty"}, caps[idx].duty, d);
      chk({nm, "_stuck_hi"}, int'(caps[idx].hi), int'(shi));
      chk({nm, "_stuck_lo"}, int'(caps[idx].lo), int'(slo));
    end else begin
      chk({nm, "_present"}, caps.size(), idx + 1);
    end
  endtask

  vec_t vecs[7];
  int   base;

  initial begin
    vecs[0] = '{"d40", 1'b1, 8'h40, 778,  3, 65,  256, 8'h40, 1'b0, 1'b0};
    vecs[1] = '{"d00", 1'b1, 8'h00, 778,  3, 1,   256, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{"dfe", 1'b1, 8'hFE, 778,  3, 255, 256, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{"d80", 1'b1, 8'h80, 778,  3, 129, 256, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{"d01", 1'b1, 8'h01, 778,  3, 2,   256, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{"dff", 1'b1, 8'hFF, 600,  1, 0,   0,   8'hFF, 1'b1, 1'b0};
    vecs[6] = '{"lo",  1'b0, 8'h00, 1000, 1, 0,   0,   8'h00, 1'b0, 1'b1};

    // reset state
    do_reset();
    #1;
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_outs", int'({high_cnt, period_cnt, duty, stuck_hi, stuck_lo}), 0);

    foreach (vecs[k]) begin
      do_reset();
      base    = caps.size();
      gen_on  = vecs[k].is_gen;
      gen_set = vecs[k].set;
      gen_g   = 8'h00;
      lvl     = 1'b0;
      run(vecs[k].ncyc);
      chk({vecs[k].name, "_nvalid"}, caps.size() - base, vecs[k].exp_nv);
      chk_cap(vecs[k].name, caps.size() - 1, vecs[k].exp_high, vecs[k].exp_period,
              vecs[k].exp_duty, vecs[k].exp_hi, vecs[k].exp_lo);
      chk({vecs[k].name, "_lvl_hi"}, int'(stuck_hi), int'(vecs[k].exp_hi));
      chk({vecs[k].name, "_lvl_lo"}, int'(stuck_lo), int'(vecs[k].exp_lo));
    end

    // duty change 0x00 -> 0xFE at a period boundary
    do_reset();
    gen_on = 1'b1; gen_set = 8'h00; gen_g = 8'h00;
    run(512);
    gen_set = 8'hFE;
    base = caps.size();
    run(522);
    chk("chg_nvalid", caps.size() - base, 3);
    chk_cap("chg_old", base, 1, 256, 8'h00, 1'b0, 1'b0);
    chk_cap("chg_new", base + 1, 255, 256, 8'hFE, 1'b0, 1'b0);

    // stuck high, then recovery with setting 0x10
    do_reset();
    gen_on = 1'b1; gen_set = 8'hFF; gen_g = 8'h00;
    run(600);
    chk("sh_flag", int'(stuck_hi), 1);
    chk("sh_duty", int'(duty), 8'hFF);
    gen_set = 8'h10; gen_g = 8'h20;
    base = caps.size();
    run(220);
    chk("sh_hold", int'(stuck_hi), 1);
    run(10);
    chk("sh_clear", int'({stuck_hi, stuck_lo}), 0);
    chk("sh_novalid", caps.size() - base, 0);
    run(256);
    chk("sh_rec_nvalid", caps.size() - base, 1);
    chk_cap("sh_rec", base, 17, 256, 8'h10, 1'b0, 1'b0);

    // reset mid-period (input low) during a 0x80 stream
    do_reset();
    gen_on = 1'b1; gen_set = 8'h80; gen_g = 8'h00;
    run(256 + 8'hA0);
    chk("mr_pre_high", int'(high_cnt), 129);
    rst_n = 1'b0;
    #1;
    chk("mr_async_outs", int'({meas_valid, high_cnt, period_cnt, duty, stuck_hi, stuck_lo}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = caps.size();
    run(104);
    chk("mr_first_rise", caps.size() - base, 0);
    run(256);
    chk("mr_nvalid", caps.size() - base, 1);
    chk_cap("mr_meas", base, 129, 256, 8'h80, 1'b0, 1'b0);

    // short glitches on a low input: 2-cycle pulse, 20 low, 1-cycle pulse
    do_reset();
    base = caps.size();
    lvl = 1'b0; run(10);
    lvl = 1'b1; run(2);
    lvl = 1'b0; run(20);
    lvl = 1'b1; run(1);
    lvl = 1'b0; run(600);
    chk("gl_stuck_lo", int'(stuck_lo), 1);
`ifdef PWM_MEAS_GLITCH_FILT_EN
    chk("gl_nvalid", caps.size() - base, 1);
    chk_cap("gl_timeout", base, 0, 0, 8'h00, 1'b0, 1'b1);
`else
    chk("gl_nvalid", caps.size() - base, 2);
    chk_cap("gl_meas", base, 2, 22, 8'h01, 1'b0, 1'b0);
    chk_cap("gl_timeout", base + 1, 2, 22, 8'h00, 1'b0, 1'b1);
`endif

    chk("no_back_to_back", dbl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
